// File: rtl/clk_switch_pkg.sv
// Shared types and defaults for the clock-switch controller.
// Optional feature macro used by the controller: CLK_SWITCH_FAILOVER_EN.
package clk_switch_pkg;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SWITCH = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } state_t;

  // Mux input indices.
  localparam int SRC_CLK0 = 0;
  localparam int SRC_CLK1 = 1;

  // Default timing: heartbeat timeout, select settle window, counter width.
  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_SETTLE  = 16;
  localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/clk_switch_ctrl_if.sv
// Request/status bundle between a switch requester and clk_switch_ctrl.
// With CLK_SWITCH_FAILOVER_EN defined the bundle also carries a failover pulse.
//
// Handshake: a request transfers on a clock edge where req_valid and
// req_ready are both high. The requester holds req_valid and req_sel stable
// until that edge; req_ready is high only while the controller is idle.
interface clk_switch_ctrl_if;
  logic req_valid;
  logic req_sel;
  logic req_ready;
  logic busy;
  logic done;
  logic err;
`ifdef CLK_SWITCH_FAILOVER_EN
  logic failover;

  modport master (output req_valid, req_sel,
                  input  req_ready, busy, done, err, failover);
  modport slave  (input  req_valid, req_sel,
                  output req_ready, busy, done, err, failover);
`else
  modport master (output req_valid, req_sel,
                  input  req_ready, busy, done, err);
  modport slave  (input  req_valid, req_sel,
                  output req_ready, busy, done, err);
`endif
endinterface

// File: rtl/clk_hb_monitor.sv
// Heartbeat monitor for one clock source: synchronises the asynchronous
// heartbeat, turns each toggle into a one-cycle pulse three reference cycles
// later, and runs a watchdog that declares the source dead after TIMEOUT
// quiet cycles.
module clk_hb_monitor
  import clk_switch_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic clk,
  input  logic nrst,
  input  logic hb,
  output logic hb_edge,
  output logic alive
);

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  logic [2:0]       sync_q;
  logic [CNT_W-1:0] cnt;

  // Two synchroniser stages, one history stage, registered toggle pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q  <= 3'b000;
      hb_edge <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], hb};
      hb_edge <= sync_q[2] ^ sync_q[1];
    end
  end

  // Watchdog: cleared by a heartbeat pulse, otherwise counts up to TIMEOUT.
  // Starts saturated so a source is dead until it proves otherwise.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= TO;
    end else if (hb_edge) begin
      cnt <= '0;
    end else if (cnt < TO) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign alive = (cnt < TO);

endmodule

// File: rtl/clk_switch_ctrl.sv
// Glitch-free clock source switch sequencer. Accepts a request, waits for a
// fresh heartbeat from the target source, flips the mux select, holds it for
// SETTLE cycles and reports done (or err when the target never ticks).
// Optional macro: CLK_SWITCH_FAILOVER_EN enables automatic failover to the
// other source when the selected one dies while idle.
module clk_switch_ctrl
  import clk_switch_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int SETTLE  = DEF_SETTLE,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    nrst,
  clk_switch_ctrl_if.slave        bus,
  input  logic                    hb0,
  input  logic                    hb1,
  output logic                    sel,
  output logic [1:0]              alive,
  output state_t                  state_dbg
);

  localparam logic [CNT_W-1:0] TO      = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SET_M1  = CNT_W'(SETTLE - 1);

  state_t           state;
  logic             target;
  logic [CNT_W-1:0] cnt;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [1:0]       hb_edge;
`ifdef CLK_SWITCH_FAILOVER_EN
  logic             fo_pend;
  logic             fo_q;
`endif

  clk_hb_monitor #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_mon0 (
    .clk     (clk),
    .nrst    (nrst),
    .hb      (hb0),
    .hb_edge (hb_edge[SRC_CLK0]),
    .alive   (alive[SRC_CLK0])
  );

  clk_hb_monitor #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_mon1 (
    .clk     (clk),
    .nrst    (nrst),
    .hb      (hb1),
    .hb_edge (hb_edge[SRC_CLK1]),
    .alive   (alive[SRC_CLK1])
  );

  // Switch sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      sel     <= 1'b0;
      target  <= 1'b0;
      cnt     <= TO;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CLK_SWITCH_FAILOVER_EN
      fo_pend <= 1'b0;
      fo_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef CLK_SWITCH_FAILOVER_EN
      fo_q   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.req_valid && ready_q) begin
            ready_q <= 1'b0;
            if (bus.req_sel == sel) begin
              // Already on the requested source: nothing to switch.
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= CHECK;
              target <= bus.req_sel;
              cnt    <= '0;
              busy_q <= 1'b1;
            end
          end
`ifdef CLK_SWITCH_FAILOVER_EN
          // An external request in the same cycle takes priority.
          else if (!alive[sel] && alive[~sel]) begin
            ready_q <= 1'b0;
            state   <= CHECK;
            target  <= ~sel;
            cnt     <= '0;
            busy_q  <= 1'b1;
            fo_pend <= 1'b1;
          end
`endif
        end
        CHECK: begin
          // Only a heartbeat seen after acceptance proves the target runs;
          // an edge on the terminal-count cycle still counts as success.
          if (hb_edge[target]) begin
            state <= SWITCH;
            sel   <= target;
            cnt   <= '0;
          end else if (cnt == TO_M1) begin
            state  <= ERROR;
            err_q  <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SWITCH: begin
          // Hold the new select while the mux hands over.
          if (cnt == SET_M1) begin
            state  <= DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
`ifdef CLK_SWITCH_FAILOVER_EN
            fo_q    <= fo_pend;
            fo_pend <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        ERROR: begin
          state   <= IDLE;
          ready_q <= 1'b1;
`ifdef CLK_SWITCH_FAILOVER_EN
          fo_pend <= 1'b0;
`endif
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
`ifdef CLK_SWITCH_FAILOVER_EN
  assign bus.failover  = fo_q;
`endif
  assign state_dbg     = state;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed-plus-random bench for clk_switch_ctrl. Heartbeat toggles are
// scheduled ahead of time in a per-source table; expected outputs are
// derived from that schedule with the timing rules of the controller.
module tb_clk_switch_ctrl;
  import clk_switch_pkg::*;

  localparam int TIMEOUT = DEF_TIMEOUT;
  localparam int SETTLE  = DEF_SETTLE;
  localparam int MAXC    = 4096;

  logic       clk;
  logic       nrst;
  logic       hb0;
  logic       hb1;
  logic       sel;
  logic [1:0] alive;
  state_t     state_dbg;

  clk_switch_ctrl_if bus ();

  clk_switch_ctrl #(.TIMEOUT(TIMEOUT), .SETTLE(SETTLE), .CNT_W(DEF_CNT_W)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .bus       (bus.slave),
    .hb0       (hb0),
    .hb1       (hb1),
    .sel       (sel),
    .alive     (alive),
    .state_dbg (state_dbg)
  );

  // Clock and global time limit.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  int   n_checks;
  int   n_fail;
  int   cyc;
  int   epoch;
  logic exp_sel;
  bit   tog [2][MAXC];

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Heartbeat toggles are applied just after the edge that starts a cycle.
  task automatic next_cycle();
    @(posedge clk);
    cyc++;
    #1;
    if (cyc < MAXC) begin
      if (tog[0][cyc]) hb0 = ~hb0;
      if (tog[1][cyc]) hb1 = ~hb1;
    end
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Rewrite the future toggle schedule of one source.
  task automatic plan_hb(input int s, input int from, input int len, input bit en,
                         input int pmin, input int pmax, input int first);
    int t;
    for (int i = from; i < from + len && i < MAXC; i++) tog[s][i] = 1'b0;
    if (en) begin
      t = from + first;
      while (t < from + len && t < MAXC) begin
        tog[s][t] = 1'b1;
        t += $urandom_range(pmax, pmin);
      end
    end
  endtask

  // A toggle in cycle t shows up as a heartbeat pulse in cycle t+3.
  function automatic bit pulse(input int s, input int e);
    int t;
    t = e - 3;
    if (t < epoch || t < 0 || t >= MAXC) return 1'b0;
    return tog[s][t];
  endfunction

  // A source is alive for TIMEOUT cycles following each pulse.
  function automatic logic [1:0] exp_alive(input int c);
    logic [1:0] r;
    r = 2'b00;
    for (int s = 0; s < 2; s++)
      for (int e = c - TIMEOUT; e < c; e++)
        if (pulse(s, e)) r[s] = 1'b1;
    return r;
  endfunction

  function automatic int first_pulse(input int s, input int lo, input int hi);
    for (int e = lo; e <= hi; e++) if (pulse(s, e)) return e;
    return -1;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      sample();
      chk("idle_sel",   sel,           exp_sel);
      chk("idle_busy",  bus.busy,      1'b0);
      chk("idle_done",  bus.done,      1'b0);
      chk("idle_err",   bus.err,       1'b0);
      chk("idle_ready", bus.req_ready, 1'b1);
      chk("idle_alive", alive,         exp_alive(cyc));
`ifdef CLK_SWITCH_FAILOVER_EN
      chk("idle_failover", bus.failover, 1'b0);
`endif
    end
  endtask

  // Asynchronous reset from mid-cycle; outputs must return at once.
  task automatic do_reset();
    bus.req_valid = 1'b0;
    nrst = 1'b0;
    #1;
    chk("rst_sel",   sel,           1'b0);
    chk("rst_busy",  bus.busy,      1'b0);
    chk("rst_ready", bus.req_ready, 1'b1);
    chk("rst_done",  bus.done,      1'b0);
    chk("rst_alive", alive,         2'b00);
    hb0 = 1'b0;
    hb1 = 1'b0;
    for (int i = cyc + 1; i < MAXC; i++) begin
      tog[0][i] = 1'b0;
      tog[1][i] = 1'b0;
    end
    repeat (3) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    nrst = 1'b1;
    epoch = cyc;
    exp_sel = 1'b0;
  endtask

  // One request from acceptance to completion. pre: request already driven
  // (held from before) or self-issued; hold_off: raise a held request that
  // many cycles into the settle window; abort_off: reset that many cycles
  // into the settle window; fo: completion expected to be a failover.
  task automatic run_req(input logic tgt, input bit pre, input int hold_off,
                         input logic tgt2, input int abort_off, input bit fo);
    int a;
    int e;
    int last;
    int sel_cyc;
    bit ok;
    bit same;
    next_cycle();
    if (!pre) begin
      bus.req_valid = 1'b1;
      bus.req_sel   = tgt;
    end
    a = cyc;
    sample();
    chk("accept_ready", bus.req_ready, 1'b1);
    ok = 1'b0;
    sel_cyc = -1;
    same = (tgt == exp_sel);
    if (same) begin
      last = a + 1;
    end else begin
      e = first_pulse(int'(tgt), a + 1, a + TIMEOUT);
      if (e >= 0) begin
        ok = 1'b1;
        sel_cyc = e + 1;
        last = e + 1 + SETTLE;
      end else begin
        last = a + 1 + TIMEOUT;
      end
    end
    for (int c = a + 1; c <= last; c++) begin
      next_cycle();
      if (c == a + 1) bus.req_valid = 1'b0;
      if (hold_off > 0 && ok && c == sel_cyc + hold_off) begin
        bus.req_valid = 1'b1;
        bus.req_sel   = tgt2;
      end
      sample();
      chk("req_sel_out", sel,           (ok && c >= sel_cyc) ? tgt : exp_sel);
      chk("req_busy",    bus.busy,      !same && c < last);
      chk("req_done",    bus.done,      c == last && (same || ok));
      chk("req_err",     bus.err,       c == last && !same && !ok);
      chk("req_ready",   bus.req_ready, 1'b0);
      chk("req_alive",   alive,         exp_alive(cyc));
`ifdef CLK_SWITCH_FAILOVER_EN
      chk("req_failover", bus.failover, c == last && ok && fo);
`endif
      if (abort_off > 0 && ok && c == sel_cyc + abort_off) begin
        do_reset();
        return;
      end
    end
    if (ok) exp_sel = tgt;
  endtask

  initial begin
    logic [1:0] nxt;
    int k;
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    epoch = 0;
    exp_sel = 1'b0;
    nrst = 1'b0;
    hb0 = 1'b0;
    hb1 = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_sel = 1'b0;

    // Reset, then both heartbeats toggling every 8 cycles.
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    sample();
    chk("reset_sel",   sel,           1'b0);
    chk("reset_ready", bus.req_ready, 1'b1);
    chk("reset_busy",  bus.busy,      1'b0);
    chk("reset_alive", alive,         2'b00);
    plan_hb(0, cyc + 1, 400, 1'b1, 8, 8, 0);
    plan_hb(1, cyc + 1, 400, 1'b1, 8, 8, 1);
    idle(12);
    chk("alive_by_12", alive, 2'b11);

    // Switch to clk1, then a request for the source already selected.
    run_req(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    idle(2);
    run_req(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    idle(1);

    // Switch back to clk0 with a second request held during settle.
    run_req(1'b0, 1'b0, 2, 1'b1, 0, 1'b0);
    run_req(1'b1, 1'b1, 0, 1'b0, 0, 1'b0);
    idle(2);

    // Random heartbeat rates, random targets and gaps.
    for (int i = 0; i < 8; i++) begin
      plan_hb(0, cyc + 1, 300, 1'b1, 4, 12, $urandom_range(3, 0));
      plan_hb(1, cyc + 1, 300, 1'b1, 4, 12, $urandom_range(3, 0));
      idle($urandom_range(4, 0));
      run_req(1'(($urandom_range(1, 0))), 1'b0, 0, 1'b0, 0, 1'b0);
    end

    // Target clk1 with its heartbeat stopped: must time out.
    if (exp_sel) run_req(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    plan_hb(0, cyc + 1, 400, 1'b1, 5, 9, 0);
    plan_hb(1, cyc + 1, 400, 1'b0, 5, 9, 0);
    idle(4);
    run_req(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("timeout_sel_kept", sel, 1'b0);
    idle(1);
    run_req(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);

    // Restart clk1, then reset in the middle of a switch.
    plan_hb(1, cyc + 1, 400, 1'b1, 5, 9, 0);
    idle(10);
    run_req(1'b1, 1'b0, 0, 1'b0, 5, 1'b0);
    plan_hb(0, cyc + 1, 400, 1'b1, 8, 8, 0);
    plan_hb(1, cyc + 1, 400, 1'b1, 8, 8, 1);
    idle(12);

    // Stop clk0 while it is selected.
    plan_hb(0, cyc + 1, 400, 1'b0, 8, 8, 0);
`ifdef CLK_SWITCH_FAILOVER_EN
    k = 0;
    nxt = exp_alive(cyc + 1);
    while (nxt[0] && k < 200) begin
      idle(1);
      k++;
      nxt = exp_alive(cyc + 1);
    end
    chk("failover_trigger_alive", nxt, 2'b10);
    run_req(1'b1, 1'b1, 0, 1'b0, 0, 1'b1);
    idle(4);
`else
    k = 0;
    nxt = 2'b00;
    idle(TIMEOUT + 16);
    chk("dead_src_alive", alive, 2'b10);
    chk("dead_src_sel",   sel,   1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
